udp_rx_pkt_fifo: RTL and testbench
==================================

// Module: udp_rx_pkt_fifo
// PURPOSE
//  Packet-atomic receive buffer directly downstream of the UDP receiver. Accepts the payload
//  byte stream (udp_d/udp_dv/udp_last/udp_port) and writes bytes for one UDP port into a RAM.
//  A packet becomes visible to the consumer only when udp_last (FCS + length good) is seen;
//  bad or abandoned packets are rolled back. Read side is a byte stream with ready/valid and
//  per-packet length, feeding the command parser.
// PARAMETERS
//  PORT        16'd11300  UDP destination port accepted; all other ports are ignored
//  AW          11         data RAM address width (2**AW bytes)
//  LW          2          length-FIFO address width (2**LW committed packets max)
//  GAP_TIMEOUT 6'd32      idle cycles without udp_dv in RX that abandon the packet
// PORTS
//  c         in   1      clock
//  rst_n     in   1      reset, synchronous, active-low
//  udp_d     in   8      payload byte
//  udp_dv    in   1      payload byte strobe
//  udp_last  in   1      packet accepted (1-cycle pulse; may coincide with a final udp_dv)
//  udp_port  in   16     destination port of current packet, stable while udp_dv high
//  rd_d      out  8      output byte
//  rd_dv     out  1      rd_d valid
//  rd_ready  in   1      consumer accepts rd_d when rd_dv & rd_ready
//  rd_first  out  1      rd_d is first byte of a packet
//  rd_last   out  1      rd_d is final byte of a packet
//  rd_len    out  AW+1   byte count of current output packet, valid while rd_dv
//  drop_cnt  out  16     saturating count of discarded packets
// BEHAVIOUR
//  Reset (rst_n=0 at edge): all pointers 0, state IDLE, rd_dv=0, rd_first=0, rd_last=0,
//   rd_len=0, drop_cnt=0, rd_d=0. Reset mid-packet discards all stored and partial data.
//  Write FSM (wr_ptr = committed tail, wr_tmp = speculative pointer, wr_cnt = AW+1 bits):
//   IDLE: udp_dv & udp_port==PORT -> RX, write byte at wr_ptr, wr_tmp=wr_ptr+1, wr_cnt=1.
//         udp_dv & port mismatch -> SKIP. udp_last in IDLE is ignored.
//   RX:   udp_dv -> write at wr_tmp, wr_tmp++, wr_cnt++, gap counter cleared.
//         udp_last (with or without same-cycle udp_dv, byte included) -> COMMIT.
//         no udp_dv for GAP_TIMEOUT cycles -> ROLLBACK (wr_tmp:=wr_ptr), drop_cnt++, IDLE.
//         write that would make data RAM full (wr_tmp+1==rd_ptr) or wr_cnt reaching 2**AW
//         -> DROP (rollback, drop_cnt++).
//   COMMIT (1 cycle): if length FIFO full -> rollback, drop_cnt++; else push wr_cnt,
//         wr_ptr:=wr_tmp. -> IDLE.
//   DROP: ignore bytes until udp_last or GAP_TIMEOUT -> IDLE. SKIP: same exit rules, no writes.
//  Empty packet (udp_last with wr_cnt 0) never enters RX; nothing is committed.
//  Pointers wrap modulo 2**AW; full when wr_tmp+1==rd_ptr (one slot kept empty).
//  Read side: show-ahead output register. When a committed byte exists and the output register
//   is empty or being consumed, RAM read issued; rd_dv rises 2 cycles after commit (1 RAM
//   latency + output reg). Sustained throughput 1 byte/cycle with rd_ready held high.
//   rd_d/rd_first/rd_last/rd_len hold while rd_dv & ~rd_ready. Length FIFO popped on rd_last
//   transfer. rd_ptr advances only on transfer; space freed becomes writable next cycle.
//  Simultaneous commit and final-byte read handled independently; no bubble required.
//  drop_cnt saturates at 16'hffff.
// STRUCTURE
//  ram_sdp sub-module: simple dual-port RAM, 1 write + 1 registered read port, params DW, AW.
//  Length FIFO is a small register array inside this module. State encodings are local.
//  PORT default and GAP_TIMEOUT default go in the shared network constants include so
//  udp_rx_pkt_fifo and the UDP transmitter agree on port numbers.
// TESTING
//  1. Port 11300, 10 bytes 0x00..0x09, udp_last with byte 9, rd_ready=1 -> rd_dv 2 cycles
//     later, bytes 0..9 in order, rd_first on 0x00, rd_last on 0x09, rd_len=10.
//  2. Same 10 bytes, no udp_last, 32 idle cycles -> no rd_dv ever, drop_cnt=1, next good
//     4-byte packet reads back with rd_len=4 from correct data.
//  3. Packet to port 11301 with udp_last -> no output, drop_cnt=0.
//  4. AW=4: 20-byte packet -> dropped, drop_cnt=1; following 5-byte packet delivered intact.
//  5. Five 3-byte packets committed with rd_ready=0 (LW=2) -> 5th dropped, drop_cnt=1; then
//     rd_ready=1 yields 4 packets, each rd_len=3, held stable while rd_ready toggles randomly.
//  6. rst_n=0 for 1 cycle during RX of packet 2 with packet 1 pending -> rd_dv=0, drop_cnt=0,
//     packet 1 lost; fresh packet after reset delivered correctly.

Source files
------------

// File: rtl/udp_rx_pkt_fifo_pkg.sv
// udp_rx_pkt_fifo_pkg: shared network constants and write-side state type for the UDP receive buffer.
package udp_rx_pkt_fifo_pkg;
  localparam logic [15:0] NET_RX_PORT = 16'd11300;
  localparam logic [5:0] NET_GAP_TIMEOUT = 6'd32;
  typedef enum logic [2:0] {IDLE, RX, COMMIT, DROP, SKIP} wr_state_e;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v == 16'hffff ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/udp_rx_pkt_fifo_ram_sdp.sv
// ram_sdp: simple dual-port RAM with one write port and one registered, enabled read port.
module ram_sdp #(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) q <= mem[ra];
  end
endmodule

// File: rtl/udp_rx_pkt_fifo.sv
// udp_rx_pkt_fifo: packet-atomic receive buffer; packets become readable only once udp_last commits them.
module udp_rx_pkt_fifo
  import udp_rx_pkt_fifo_pkg::*;
#(
  parameter logic [15:0] PORT        = NET_RX_PORT,
  parameter int          AW          = 11,
  parameter int          LW          = 2,
  parameter logic [5:0]  GAP_TIMEOUT = NET_GAP_TIMEOUT
) (
  input  logic        c,
  input  logic        rst_n,
  input  logic [7:0]  udp_d,
  input  logic        udp_dv,
  input  logic        udp_last,
  input  logic [15:0] udp_port,
  output logic [7:0]  rd_d,
  output logic        rd_dv,
  input  logic        rd_ready,
  output logic        rd_first,
  output logic        rd_last,
  output logic [AW:0] rd_len,
  output logic [15:0] drop_cnt
);
  localparam logic [AW-1:0] P1 = 1;
  localparam logic [AW:0]   C1 = 1;
  localparam logic [LW-1:0] L1 = 1;
  wr_state_e st;
  logic [AW-1:0] wr_ptr, wr_tmp, rd_ptr, ft_ptr, wa;
  logic [AW:0] wr_cnt, ft_cnt, s1_len;
  logic [AW:0] lf_mem [2**LW];
  logic [LW-1:0] lf_wp, ft_lf;
  logic [LW:0] lf_cnt;
  logic [5:0] gap;
  logic [7:0] wd, q;
  logic we, s1_v, s1_first, s1_last;
  logic xfer, move, issue, ft_last, gap_out, full_ptr, full_tmp, len_max, lf_full, lf_push, lf_pop;
  assign xfer     = rd_dv & rd_ready;
  assign move     = s1_v & (~rd_dv | rd_ready);
  assign issue    = (ft_ptr != wr_ptr) & (~s1_v | move);
  assign ft_last  = ft_cnt + C1 == lf_mem[ft_lf];
  assign gap_out  = ~udp_dv & (gap == GAP_TIMEOUT - 6'd1);
  assign full_ptr = wr_ptr + P1 == rd_ptr;
  assign full_tmp = wr_tmp + P1 == rd_ptr;
  assign len_max  = wr_cnt == {1'b0, {AW{1'b1}}};
  assign lf_full  = lf_cnt == {1'b1, {LW{1'b0}}};
  assign lf_push  = st == COMMIT & ~lf_full;
  assign lf_pop   = xfer & rd_last;
  // Write side: bytes land speculatively at wr_tmp; wr_ptr only moves on a successful commit.
  always_ff @(posedge c) begin
    we <= 1'b0;
    if (!rst_n) begin
      st <= IDLE;
      wr_ptr <= '0;
      wr_tmp <= '0;
      wr_cnt <= '0;
      gap <= '0;
      drop_cnt <= '0;
      wa <= '0;
      wd <= '0;
      lf_wp <= '0;
    end else begin
      gap <= udp_dv ? 6'd0 : gap + 6'd1;
      case (st)
        IDLE: if (udp_dv) begin
          if (udp_port != PORT) st <= udp_last ? IDLE : SKIP;
          else if (full_ptr) begin
            st <= udp_last ? IDLE : DROP;
            drop_cnt <= sat_inc(drop_cnt);
          end else begin
            we <= 1'b1;
            wa <= wr_ptr;
            wd <= udp_d;
            wr_tmp <= wr_ptr + P1;
            wr_cnt <= C1;
            st <= udp_last ? COMMIT : RX;
          end
        end
        RX: if ((udp_dv && (full_tmp || len_max)) || gap_out) begin
          wr_tmp <= wr_ptr;
          drop_cnt <= sat_inc(drop_cnt);
          st <= (gap_out || udp_last) ? IDLE : DROP;
        end else begin
          if (udp_dv) begin
            we <= 1'b1;
            wa <= wr_tmp;
            wd <= udp_d;
            wr_tmp <= wr_tmp + P1;
            wr_cnt <= wr_cnt + C1;
          end
          if (udp_last) st <= COMMIT;
        end
        COMMIT: begin
          if (lf_full) begin
            wr_tmp <= wr_ptr;
            drop_cnt <= sat_inc(drop_cnt);
          end else begin
            lf_mem[lf_wp] <= wr_cnt;
            lf_wp <= lf_wp + L1;
            wr_ptr <= wr_tmp;
          end
          st <= IDLE;
        end
        default: if (udp_last || gap_out) st <= IDLE;
      endcase
    end
  end
  // Read side: fetch runs up to two bytes ahead of rd_ptr (RAM stage + output register).
  always_ff @(posedge c) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      ft_ptr <= '0;
      ft_cnt <= '0;
      ft_lf <= '0;
      lf_cnt <= '0;
      s1_v <= 1'b0;
      s1_first <= 1'b0;
      s1_last <= 1'b0;
      s1_len <= '0;
      rd_dv <= 1'b0;
      rd_d <= '0;
      rd_first <= 1'b0;
      rd_last <= 1'b0;
      rd_len <= '0;
    end else begin
      lf_cnt <= lf_cnt + {{LW{1'b0}}, lf_push} - {{LW{1'b0}}, lf_pop};
      if (xfer) rd_ptr <= rd_ptr + P1;
      if (issue) begin
        ft_ptr <= ft_ptr + P1;
        ft_cnt <= ft_last ? '0 : ft_cnt + C1;
        ft_lf <= ft_last ? ft_lf + L1 : ft_lf;
        s1_first <= ft_cnt == '0;
        s1_last <= ft_last;
        s1_len <= lf_mem[ft_lf];
      end
      if (move) begin
        rd_d <= q;
        rd_first <= s1_first;
        rd_last <= s1_last;
        rd_len <= s1_len;
      end
      s1_v <= issue | (s1_v & ~move);
      rd_dv <= move | (rd_dv & ~rd_ready);
    end
  end
  ram_sdp #(.DW(8), .AW(AW)) u_ram (
    .clk(c), .we(we), .wa(wa), .wd(wd), .re(issue), .ra(ft_ptr), .q(q)
  );
endmodule

// File: tb/tb_udp_rx_pkt_fifo.sv
// tb_udp_rx_pkt_fifo: directed and randomized checks of the packet FIFO against a packet-level model.
module tb_udp_rx_pkt_fifo;
  localparam logic [15:0] PORT = 16'd11300;
  typedef logic [7:0] bq_t[$];
  typedef logic [22:0] ent_t;
  logic clk = 1'b0, rst_n = 1'b0, udp_dv = 1'b0, udp_last = 1'b0, rd_ready = 1'b1, sel = 1'b0;
  logic [7:0] udp_d = '0;
  logic [15:0] udp_port = '0;
  logic dv0, dv1, last0, last1, v0, v1, f0, f1, l0, l1;
  logic [7:0] d0, d1;
  logic [11:0] len0;
  logic [4:0] len1;
  logic [15:0] dc0, dc1;
  logic o_dv, o_first, o_last;
  logic [7:0] o_d;
  logic [11:0] o_len;
  int tests = 0, fails = 0, m_stored = 0, m_pend = 0;
  int exp_drop [2] = '{0, 0};
  bit rr_rand = 0, p_stall = 0;
  ent_t p_val, got[$], expq[$];
  always #5 clk = ~clk;
  assign dv0 = udp_dv & ~sel;
  assign dv1 = udp_dv & sel;
  assign last0 = udp_last & ~sel;
  assign last1 = udp_last & sel;
  assign o_dv = sel ? v1 : v0;
  assign o_first = sel ? f1 : f0;
  assign o_last = sel ? l1 : l0;
  assign o_d = sel ? d1 : d0;
  assign o_len = sel ? {7'b0, len1} : len0;
  udp_rx_pkt_fifo dut (
    .c(clk), .rst_n(rst_n), .udp_d(udp_d), .udp_dv(dv0), .udp_last(last0), .udp_port(udp_port),
    .rd_d(d0), .rd_dv(v0), .rd_ready(rd_ready), .rd_first(f0), .rd_last(l0), .rd_len(len0), .drop_cnt(dc0)
  );
  udp_rx_pkt_fifo #(.AW(4)) dut_small (
    .c(clk), .rst_n(rst_n), .udp_d(udp_d), .udp_dv(dv1), .udp_last(last1), .udp_port(udp_port),
    .rd_d(d1), .rd_dv(v1), .rd_ready(rd_ready), .rd_first(f1), .rd_last(l1), .rd_len(len1), .drop_cnt(dc1)
  );
  function automatic ent_t cur();
    return {o_dv, o_first, o_last, o_len, o_d};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  // One cycle: record the transfer about to happen, check that stalled outputs held.
  task automatic tick();
    if (rr_rand) rd_ready = 1'($urandom_range(0, 1));
    if (p_stall) chk("hold_while_stalled", 32'(cur()), 32'(p_val));
    p_stall = o_dv & ~rd_ready;
    p_val = cur();
    if (o_dv & rd_ready) got.push_back(cur());
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] port, input bq_t data, input bit last, input int gmax, input int post);
    int n;
    int cap;
    bit acc;
    n = data.size();
    cap = sel ? 15 : 2047;
    acc = port == PORT && last && m_stored + n <= cap && m_pend < 4;
    for (int i = 0; i < n; i++) begin
      udp_port = port;
      udp_d = data[i];
      udp_dv = 1'b1;
      udp_last = last && i == n - 1;
      tick();
      udp_dv = 1'b0;
      udp_last = 1'b0;
      if (i < n - 1) repeat ($urandom_range(0, gmax)) tick();
    end
    repeat (last ? post : 40) tick();
    if (acc) begin
      for (int i = 0; i < n; i++) expq.push_back({1'b1, i == 0, i == n - 1, 12'(n), data[i]});
      m_stored += n;
      m_pend++;
    end else if (port == PORT) exp_drop[sel]++;
  endtask
  function automatic bq_t rnd_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (got.size() < expq.size() && n < 2000) begin
      tick();
      n++;
    end
    repeat (10) tick();
    chk({tag, "_count"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++) chk({tag, "_byte"}, 32'(got[i]), 32'(expq[i]));
    chk({tag, "_drop_cnt"}, sel ? dc1 : dc0, exp_drop[sel]);
    got.delete();
    expq.delete();
    m_stored = 0;
    m_pend = 0;
  endtask
  initial begin
    bq_t b;
    int n;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_rd_dv", v0, 0);
    chk("rst_rd_first", f0, 0);
    chk("rst_rd_last", l0, 0);
    chk("rst_rd_len", len0, 0);
    chk("rst_rd_d", d0, 0);
    chk("rst_drop_cnt", dc0, 0);
    chk("rst_drop_cnt_small", dc1, 0);
    b = {};
    for (int i = 0; i < 10; i++) b.push_back(8'(i));
    send(PORT, b, 1, 0, 0);
    n = 0;
    while (!o_dv && n < 8) begin
      tick();
      n++;
    end
    chk("t1_rd_dv_rises", 32'(n < 8), 1);
    drain("t1");
    send(PORT, b, 0, 0, 0);
    drain("t2_abandon");
    send(PORT, rnd_bytes(4), 1, 2, 3);
    drain("t2_next");
    send(PORT + 16'd1, rnd_bytes(8), 1, 1, 3);
    drain("t3_other_port");
    sel = 1'b1;
    send(PORT, rnd_bytes(20), 1, 0, 3);
    send(PORT, rnd_bytes(5), 1, 0, 3);
    drain("t4_small");
    sel = 1'b0;
    rd_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(PORT, rnd_bytes(3), 1, 1, 3);
    chk("t5_drop_cnt", dc0, exp_drop[0]);
    rr_rand = 1;
    drain("t5_fifo_full");
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 3; j++)
        send(($urandom_range(0, 4) != 0) ? PORT : PORT + 16'($urandom_range(1, 9)),
             rnd_bytes($urandom_range(2, 40)), $urandom_range(0, 4) != 0, 3, 3);
      drain("rand");
    end
    rr_rand = 0;
    rd_ready = 1'b0;
    send(PORT, rnd_bytes(3), 1, 0, 3);
    for (int i = 0; i < 4; i++) begin
      udp_port = PORT;
      udp_d = 8'(i);
      udp_dv = 1'b1;
      tick();
    end
    udp_dv = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    p_stall = 0;
    got.delete();
    expq.delete();
    exp_drop = '{0, 0};
    m_stored = 0;
    m_pend = 0;
    tick();
    chk("t6_rd_dv_after_rst", v0, 0);
    chk("t6_drop_cnt_after_rst", dc0, 0);
    rd_ready = 1'b1;
    drain("t6_lost");
    send(PORT, rnd_bytes(6), 1, 1, 3);
    drain("t6_fresh");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
